// File: rtl/player_health_if.sv
// Game-side signals of player_health: fireball/player geometry in, HP status out.
// The design sits on the slave modport; the attack logic / game controller side uses master.
interface player_health_if;
  logic [3:0] game_state;
  logic [9:0] BallX;
  logic [9:0] BallY;
  logic [9:0] BallS;
  logic [9:0] fireballX;
  logic [9:0] fireballY;
  logic [9:0] fireballS;
  logic       fireball_exist;
  logic [2:0] hp;
  logic       hit_pulse;
  logic       player_blink;
  logic       player_dead;

  modport master (
    output game_state, BallX, BallY, BallS,
    output fireballX, fireballY, fireballS, fireball_exist,
    input  hp, hit_pulse, player_blink, player_dead
  );

  modport slave (
    input  game_state, BallX, BallY, BallS,
    input  fireballX, fireballY, fireballS, fireball_exist,
    output hp, hit_pulse, player_blink, player_dead
  );
endinterface

// File: rtl/player_health.sv
// Player hit-point tracker: one hit per fireball flight, post-hit invulnerability, death flag.
// Optional HP regeneration while unhurt is enabled by defining HEALTH_REGEN_EN.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | not playing; hp restored to MAX_HP, counters and consumed clear
// S_ALIVE  | playing; an unconsumed overlap charges one hit
// S_INVULN | post-hit i-frames; overlaps ignored, blink follows counter bit 3
// S_DEAD   | hp is 0; held until game_state leaves gameplay
module player_health #(
  parameter int MAX_HP       = 5,
  parameter int IFRAMES      = 60,
  parameter int REGEN_FRAMES = 300
) (
  input  logic           frame_clk,
  input  logic           Reset_n,
  player_health_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ALIVE  = 2'd1,
    S_INVULN = 2'd2,
    S_DEAD   = 2'd3
  } state_t;

  localparam logic [2:0] HP_MAX   = 3'(MAX_HP);
  localparam logic [9:0] IFR_LOAD = 10'(IFRAMES - 1);
  localparam logic [3:0] GS_PLAY  = 4'd2;

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_hp, w_hp_nxt;
  logic        r_hit_pulse, w_hit_pulse_nxt;
  logic        r_consumed, w_consumed_nxt;
  logic [9:0]  r_ifr_cnt, w_ifr_cnt_nxt;

  logic [10:0] w_dx;
  logic [10:0] w_dy;
  logic [10:0] w_reach;
  logic        w_overlap;
  logic        w_playing;

`ifdef HEALTH_REGEN_EN
  localparam logic [15:0] REGEN_LAST = 16'(REGEN_FRAMES - 1);
  logic [15:0] r_regen_cnt, w_regen_cnt_nxt;
`endif

  // Distances are formed at 11 bits so the subtraction never wraps.
  always_comb begin
    if (bus.fireballX >= bus.BallX) begin
      w_dx = {1'b0, bus.fireballX} - {1'b0, bus.BallX};
    end else begin
      w_dx = {1'b0, bus.BallX} - {1'b0, bus.fireballX};
    end
    if (bus.fireballY >= bus.BallY) begin
      w_dy = {1'b0, bus.fireballY} - {1'b0, bus.BallY};
    end else begin
      w_dy = {1'b0, bus.BallY} - {1'b0, bus.fireballY};
    end
  end

  assign w_reach   = {1'b0, bus.fireballS} + {1'b0, bus.BallS};
  assign w_overlap = bus.fireball_exist && (w_dx <= w_reach) && (w_dy <= w_reach);
  assign w_playing = (bus.game_state == GS_PLAY);

  always_comb begin
    w_state_nxt     = r_state;
    w_hp_nxt        = r_hp;
    w_hit_pulse_nxt = 1'b0;
    w_consumed_nxt  = r_consumed;
    w_ifr_cnt_nxt   = r_ifr_cnt;
`ifdef HEALTH_REGEN_EN
    w_regen_cnt_nxt = r_regen_cnt;
`endif

    if (!w_playing) begin
      // Round restart outranks anything happening this frame, including a hit.
      w_state_nxt    = S_IDLE;
      w_hp_nxt       = HP_MAX;
      w_consumed_nxt = 1'b0;
      w_ifr_cnt_nxt  = '0;
`ifdef HEALTH_REGEN_EN
      w_regen_cnt_nxt = '0;
`endif
    end else begin
      if (!bus.fireball_exist) begin
        w_consumed_nxt = 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          w_state_nxt    = S_ALIVE;
          w_hp_nxt       = HP_MAX;
          w_consumed_nxt = 1'b0;
          w_ifr_cnt_nxt  = '0;
`ifdef HEALTH_REGEN_EN
          w_regen_cnt_nxt = '0;
`endif
        end

        S_ALIVE: begin
          if (w_overlap && !r_consumed) begin
            w_hit_pulse_nxt = 1'b1;
            w_consumed_nxt  = 1'b1;
            w_ifr_cnt_nxt   = IFR_LOAD;
            w_hp_nxt        = (r_hp != 3'd0) ? (r_hp - 3'd1) : 3'd0;
            w_state_nxt     = (w_hp_nxt == 3'd0) ? S_DEAD : S_INVULN;
`ifdef HEALTH_REGEN_EN
            w_regen_cnt_nxt = '0;
`endif
          end
`ifdef HEALTH_REGEN_EN
          else if (r_hp < HP_MAX) begin
            if (r_regen_cnt >= REGEN_LAST) begin
              w_hp_nxt        = r_hp + 3'd1;
              w_regen_cnt_nxt = '0;
            end else begin
              w_regen_cnt_nxt = r_regen_cnt + 16'd1;
            end
          end
`endif
        end

        S_INVULN: begin
          // Leaving on the zero frame means an overlap in that frame is not charged.
          if (r_ifr_cnt == 10'd0) begin
            w_state_nxt = S_ALIVE;
          end else begin
            w_ifr_cnt_nxt = r_ifr_cnt - 10'd1;
          end
        end

        S_DEAD: begin
          w_hp_nxt      = 3'd0;
          w_ifr_cnt_nxt = '0;
`ifdef HEALTH_REGEN_EN
          w_regen_cnt_nxt = '0;
`endif
        end

        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_hp        <= HP_MAX;
      r_hit_pulse <= 1'b0;
      r_consumed  <= 1'b0;
      r_ifr_cnt   <= '0;
    end else begin
      r_hp        <= w_hp_nxt;
      r_hit_pulse <= w_hit_pulse_nxt;
      r_consumed  <= w_consumed_nxt;
      r_ifr_cnt   <= w_ifr_cnt_nxt;
    end
  end

`ifdef HEALTH_REGEN_EN
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_regen_cnt <= '0;
    end else begin
      r_regen_cnt <= w_regen_cnt_nxt;
    end
  end
`endif

  assign bus.hp           = r_hp;
  assign bus.hit_pulse    = r_hit_pulse;
  assign bus.player_blink = (r_state == S_INVULN) && r_ifr_cnt[3];
  assign bus.player_dead  = (r_state == S_DEAD);

endmodule

// File: tb/tb_player_health.sv
// Directed bench for player_health: expected outputs queued with each stimulus step,
// then popped and checked one frame later.
module tb_player_health;

  logic frame_clk;
  logic Reset_n;

  player_health_if bus ();

  player_health dut (
    .frame_clk (frame_clk),
    .Reset_n   (Reset_n),
    .bus       (bus)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  typedef struct {
    string      tag;
    logic [2:0] hp;
    logic       hit;
    logic       blink;
    logic       dead;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Blink expected k frames after a hit with 60 i-frames (counter = 59 - k).
  function automatic logic blink_exp(int k);
    int cnt;
    if (k > 59) return 1'b0;
    cnt = 59 - k;
    return logic'((cnt >> 3) & 1);
  endfunction

  task automatic push_exp(string tag, logic [2:0] hp, logic hit, logic blink, logic dead);
    exp_t e;
    e.tag = tag; e.hp = hp; e.hit = hit; e.blink = blink; e.dead = dead;
    sb_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    e = sb_q.pop_front();
    n_tests++;
    assert (bus.hp === e.hp) else begin
      n_fail++;
      $error("FAIL %s hp: got %0d expected %0d", e.tag, bus.hp, e.hp);
    end
    n_tests++;
    assert (bus.hit_pulse === e.hit) else begin
      n_fail++;
      $error("FAIL %s hit_pulse: got %b expected %b", e.tag, bus.hit_pulse, e.hit);
    end
    n_tests++;
    assert (bus.player_blink === e.blink) else begin
      n_fail++;
      $error("FAIL %s player_blink: got %b expected %b", e.tag, bus.player_blink, e.blink);
    end
    n_tests++;
    assert (bus.player_dead === e.dead) else begin
      n_fail++;
      $error("FAIL %s player_dead: got %b expected %b", e.tag, bus.player_dead, e.dead);
    end
  endtask

  task automatic step(string tag, logic [2:0] hp, logic hit, logic blink, logic dead);
    push_exp(tag, hp, hit, blink, dead);
    @(posedge frame_clk);
    #1;
    check_out();
  endtask

  task automatic check_now(string tag, logic [2:0] hp, logic hit, logic blink, logic dead);
    push_exp(tag, hp, hit, blink, dead);
    check_out();
  endtask

  task automatic set_fb(int x, int y, int s, logic ex);
    bus.fireballX      = 10'(x);
    bus.fireballY      = 10'(y);
    bus.fireballS      = 10'(s);
    bus.fireball_exist = ex;
  endtask

  initial begin
    Reset_n        = 1'b1;
    bus.game_state = 4'd0;
    bus.BallX      = 10'd300;
    bus.BallY      = 10'd240;
    bus.BallS      = 10'd16;
    set_fb(310, 250, 8, 1'b0);

    #2 Reset_n = 1'b0;
    #1 check_now("reset", 3'd5, 1'b0, 1'b0, 1'b0);
    @(posedge frame_clk); #1;
    Reset_n = 1'b1;

    step("idle", 3'd5, 1'b0, 1'b0, 1'b0);
    bus.game_state = 4'd2;
    step("enter_alive", 3'd5, 1'b0, 1'b0, 1'b0);

    // single hit then full i-frame window
    bus.fireball_exist = 1'b1;
    step("hit1", 3'd4, 1'b1, 1'b1, 1'b0);
    bus.fireball_exist = 1'b0;
    for (int k = 1; k <= 60; k++)
      step($sformatf("ifr1_%0d", k), 3'd4, 1'b0, blink_exp(k), 1'b0);

    // lingering fireball: only the first frame charges
    bus.fireball_exist = 1'b1;
    for (int i = 0; i < 200; i++)
      step($sformatf("linger_%0d", i), 3'd3, logic'(i == 0), blink_exp(i), 1'b0);
    bus.fireball_exist = 1'b0;
    step("drop_exist", 3'd3, 1'b0, 1'b0, 1'b0);
    bus.fireball_exist = 1'b1;
    step("rehit", 3'd2, 1'b1, 1'b1, 1'b0);
    bus.fireball_exist = 1'b0;
    for (int k = 1; k <= 60; k++)
      step($sformatf("ifr2_%0d", k), 3'd2, 1'b0, blink_exp(k), 1'b0);

    // near miss at dx=35, inclusive hit at dx=24
    set_fb(335, 240, 8, 1'b1);
    for (int i = 0; i < 3; i++)
      step($sformatf("miss35_%0d", i), 3'd2, 1'b0, 1'b0, 1'b0);
    set_fb(324, 240, 8, 1'b1);
    step("edge24", 3'd1, 1'b1, 1'b1, 1'b0);
    bus.fireball_exist = 1'b0;
    for (int k = 1; k <= 60; k++)
      step($sformatf("ifr3_%0d", k), 3'd1, 1'b0, blink_exp(k), 1'b0);

    // left side: dx=25 misses, dx=24 kills
    set_fb(275, 240, 8, 1'b1);
    step("miss25_left", 3'd1, 1'b0, 1'b0, 1'b0);
    set_fb(276, 240, 8, 1'b1);
    step("kill", 3'd0, 1'b1, 1'b0, 1'b1);
    bus.fireball_exist = 1'b0;
    step("dead_a", 3'd0, 1'b0, 1'b0, 1'b1);
    bus.fireball_exist = 1'b1;
    step("dead_b", 3'd0, 1'b0, 1'b0, 1'b1);
    step("dead_c", 3'd0, 1'b0, 1'b0, 1'b1);
    bus.game_state = 4'd0;
    step("restart", 3'd5, 1'b0, 1'b0, 1'b0);

    // overlapping geometry without fireball_exist
    bus.game_state = 4'd2;
    set_fb(310, 250, 8, 1'b0);
    step("alive2", 3'd5, 1'b0, 1'b0, 1'b0);
    step("no_exist", 3'd5, 1'b0, 1'b0, 1'b0);

    // leaving gameplay in the overlap frame wins over the hit
    bus.fireball_exist = 1'b1;
    bus.game_state     = 4'd0;
    step("abort_overlap", 3'd5, 1'b0, 1'b0, 1'b0);

    // abort at frame 30 of the i-frames
    bus.game_state     = 4'd2;
    bus.fireball_exist = 1'b0;
    step("alive3", 3'd5, 1'b0, 1'b0, 1'b0);
    bus.fireball_exist = 1'b1;
    step("hit_a", 3'd4, 1'b1, 1'b1, 1'b0);
    bus.fireball_exist = 1'b0;
    for (int k = 1; k <= 29; k++)
      step($sformatf("ifr4_%0d", k), 3'd4, 1'b0, blink_exp(k), 1'b0);
    bus.game_state = 4'd0;
    step("abort_invuln", 3'd5, 1'b0, 1'b0, 1'b0);

    // overlap held through INVULN->ALIVE frame is charged one frame later
    bus.game_state = 4'd2;
    step("alive4", 3'd5, 1'b0, 1'b0, 1'b0);
    bus.fireball_exist = 1'b1;
    step("hit_b", 3'd4, 1'b1, 1'b1, 1'b0);
    bus.fireball_exist = 1'b0;
    step("ifr5_1", 3'd4, 1'b0, blink_exp(1), 1'b0);
    bus.fireball_exist = 1'b1;
    for (int k = 2; k <= 60; k++)
      step($sformatf("ifr5_%0d", k), 3'd4, 1'b0, blink_exp(k), 1'b0);
    step("late_hit", 3'd3, 1'b1, 1'b1, 1'b0);

    // asynchronous reset between edges while in INVULN with a pulse showing
    #3 Reset_n = 1'b0;
    #1 check_now("async_rst", 3'd5, 1'b0, 1'b0, 1'b0);
    bus.fireball_exist = 1'b0;
    @(posedge frame_clk); #1;
    check_now("rst_held", 3'd5, 1'b0, 1'b0, 1'b0);
    Reset_n = 1'b1;
    step("post_rst", 3'd5, 1'b0, 1'b0, 1'b0);
    bus.fireball_exist = 1'b1;
    step("post_rst_hit", 3'd4, 1'b1, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/player_health.md
# player_health

Tracks the player's hit points against the monster's fireball during gameplay. It sits directly downstream of the monster attack logic and consumes its fireball position, size and existence flag, together with the player ball position. It detects fireball/player overlap and charges at most one hit per fireball flight. It applies a post-hit invulnerability window and drives HP, blink and death outputs to the sprite renderer and the game-state controller.

## Interface
Parameters:
- MAX_HP, 5: starting and maximum hit points, range 1..7.
- IFRAMES, 60: invulnerability length in frames after a hit, range 1..1023.
- REGEN_FRAMES, 300: hit-free frames per regenerated HP. Used only with HEALTH_REGEN_EN.

Ports:
- frame_clk, in, 1: frame clock. All state updates on its rising edge.
- Reset_n, in, 1: asynchronous, active-low reset.
- game_state, in, 4: value 4'd2 means gameplay. Any other value means not playing.
- BallX, BallY, BallS, in, 10 each: player centre and half-size.
- fireballX, fireballY, fireballS, in, 10 each: fireball centre and half-size.
- fireball_exist, in, 1: fireball is in flight.
- hp, out, 3: current hit points.
- hit_pulse, out, 1: one-frame pulse for each charged hit.
- player_blink, out, 1: sprite blink enable, asserted during invulnerability.
- player_dead, out, 1: HP has reached 0. Level-held.

## Operation
- Overlap test, combinational on current inputs:
  - dx = |fireballX − BallX| and dy = |fireballY − BallY|, each computed at 11 bits so no wrap occurs.
  - overlap = fireball_exist && dx <= fireballS+BallS && dy <= fireballS+BallS. Sums are 11 bits.
- consumed flag:
  - Set when a hit is charged.
  - Cleared in the first frame in which fireball_exist = 0.
  - While set, overlap is ignored.
- State machine, states IDLE, ALIVE, INVULN, DEAD:
  - IDLE: hp = MAX_HP, all counters 0, consumed = 0. Goes to ALIVE when game_state == 2.
  - ALIVE: if overlap && !consumed, then hp −1, hit_pulse = 1, consumed = 1, i-frame counter loaded with IFRAMES−1. Next state is DEAD if the new hp == 0, otherwise INVULN.
  - INVULN: player_blink = bit 3 of the i-frame counter (toggles every 8 frames). Overlaps are ignored and do not set consumed. The counter decrements each frame and the state returns to ALIVE on the frame the counter is 0.
  - DEAD: player_dead = 1 and hp holds at 0. Exited only to IDLE.
- From any state, game_state != 2 forces IDLE on the next edge. This is the level/round restart path.
- hp is saturated to the range 0..MAX_HP and never underflows.

## Timing
- Reset (Reset_n low, asynchronous): state IDLE, hp = MAX_HP, hit_pulse = 0, player_blink = 0, player_dead = 0, consumed = 0, counters 0.
- Reset is released synchronously to frame_clk by the top level. The block does no internal synchronisation.
- Latency: overlap sampled at edge N gives hp, hit_pulse and the state change visible after edge N. hit_pulse is high for exactly one frame.
- An overlap during the very frame the state returns INVULN→ALIVE is not charged. It is evaluated on the next frame in ALIVE.
- If fireball_exist falls in the same frame as an overlap, no hit is charged, because overlap requires fireball_exist.
- game_state leaving 2 in the same frame as an overlap: IDLE wins and no hit is charged.
- If Reset_n is asserted mid-INVULN, the state and counter clear immediately.

## Configuration
- HEALTH_REGEN_EN defined:
  - A regen counter increments each frame in ALIVE while hp < MAX_HP.
  - When the counter reaches REGEN_FRAMES−1: hp +1, counter cleared.
  - The counter also clears on any charged hit, in IDLE, and in DEAD.
  - hp never exceeds MAX_HP.
- HEALTH_REGEN_EN undefined: no regen counter is synthesised. hp only decreases until IDLE restores it.

## Test plan
- Single hit: reset, game_state = 2, Ball (300,240,S=16), fireball (310,250,S=8) with exist = 1 for 1 frame → hp 5→4, one hit_pulse, then INVULN for 60 frames with player_blink toggling every 8 frames.
- Lingering fireball: the fireball stays overlapped for 200 frames → exactly one hit (hp = 4). Drop exist for 1 frame, then re-overlap → second hit (hp = 3).
- Near miss: fireball (335,240,S=8) with Ball S = 16, so dx = 35 > 24 → no hit. At dx = 24 → hit charged (inclusive bound).
- Death: 5 separate fireball flights, each after the i-frames expire → hp reaches 0 and player_dead = 1. Further overlaps leave hp = 0. game_state = 0 → hp = 5, player_dead = 0.
- Abort mid-INVULN: game_state drops to 0 at frame 30 of the i-frames → IDLE next frame, blink = 0. Assert Reset_n low asynchronously between edges → outputs clear immediately.
- With HEALTH_REGEN_EN defined, REGEN_FRAMES = 300: hp = 4, no hits → hp = 5 after 300 frames in ALIVE and stays at 5. A hit at frame 299 → no regen, counter restarts.
